divider: RTL and testbench

Iterative 32-bit integer divider for the RV32M datapath, paired with the iterative multiplier in the execute stage. It implements DIV, DIVU, REM and REMU with a fixed-latency radix-2 restoring algorithm, one quotient bit per cycle. It uses the same single-pulse `vld_i`/`rdy_o` handshake as the multiplier, so the issue logic can treat both units identically.

---
 rtl/rays_pkg.sv | 18 +
 rtl/div_abs_neg.sv | 13 +
 rtl/divider.sv | 159 +++++++++++++++
 tb/tb_divider.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rays_pkg.sv
// Shared RV32M execute-stage definitions: widths, divider latency, FSM states
// and the architecturally defined special-case results.
package rays_pkg;

  localparam int XLEN        = 32;
  localparam int DIV_LATENCY = 34;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

endpackage

// File: rtl/div_abs_neg.sv
// Conditional two's-complement negate: used both to take operand magnitudes
// and to restore the sign of the quotient and remainder.
module div_abs_neg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val,
  input  logic             neg,
  output logic [WIDTH-1:0] out
);

  assign out = neg ? (~val + 1'b1) : val;

endmodule

// File: rtl/divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with a fixed
// 34-cycle latency and a single-pulse vld_i/rdy_o handshake.
module divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic            signed_i,
  input  logic            vld_i,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o,
  output logic            rdy_o,
  output logic            busy_o
);

  import rays_pkg::*;

  div_state_t      state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] part_q, part_d;
  logic [XLEN-1:0] orig_q, orig_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic            dvs_zero_q, dvs_zero_d;
  logic            ovf_q, ovf_d;

  logic [XLEN-1:0] op1_abs, op2_abs, quot_fix, rem_fix;
  logic [XLEN:0]   shifted, trial;

  div_abs_neg #(.WIDTH(XLEN)) u_abs_op1 (
    .val (op1_i),
    .neg (signed_i & op1_i[XLEN-1]),
    .out (op1_abs)
  );

  div_abs_neg #(.WIDTH(XLEN)) u_abs_op2 (
    .val (op2_i),
    .neg (signed_i & op2_i[XLEN-1]),
    .out (op2_abs)
  );

  div_abs_neg #(.WIDTH(XLEN)) u_fix_quot (
    .val (dvd_q),
    .neg (q_neg_q),
    .out (quot_fix)
  );

  div_abs_neg #(.WIDTH(XLEN)) u_fix_rem (
    .val (part_q),
    .neg (r_neg_q),
    .out (rem_fix)
  );

  // 33-bit trial keeps a 2^31 magnitude (from -2^31) positive
  assign shifted = {part_q, dvd_q[XLEN-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    part_d     = part_q;
    orig_d     = orig_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    dvs_zero_d = dvs_zero_q;
    ovf_d      = ovf_q;

    case (state_q)
      IDLE: begin
        if (vld_i) begin
          state_d    = CALC;
          cnt_d      = '0;
          dvd_d      = op1_abs;
          dvs_d      = op2_abs;
          part_d     = '0;
          orig_d     = op1_i;
          q_neg_d    = signed_i & (op1_i[XLEN-1] ^ op2_i[XLEN-1]);
          r_neg_d    = signed_i & op1_i[XLEN-1];
          dvs_zero_d = (op2_i == '0);
          ovf_d      = signed_i && (op1_i == INT_MIN) && (op2_i == '1);
        end
      end
      CALC: begin
        part_d = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
        dvd_d  = {dvd_q[XLEN-2:0], ~trial[XLEN]};
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'(XLEN - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        // special cases are forced so they never depend on the datapath
        if (dvs_zero_q) begin
          quot_d = DIV_BY_ZERO_Q;
          rem_d  = orig_q;
        end else if (ovf_q) begin
          quot_d = INT_MIN;
          rem_d  = '0;
        end else begin
          quot_d = quot_fix;
          rem_d  = rem_fix;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      part_q     <= '0;
      orig_q     <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      dvs_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      part_q     <= part_d;
      orig_q     <= orig_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      dvs_zero_q <= dvs_zero_d;
      ovf_q      <= ovf_d;
    end
  end

  assign quot_o = quot_q;
  assign rem_o  = rem_q;
  assign rdy_o  = (state_q == DONE);
  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_divider.sv
// Directed scoreboard bench for the iterative divider: results, latency,
// special cases, held-vld handshake and reset abort.
module tb_divider;

  import rays_pkg::*;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] op1, op2;
  logic        sgn, vld;
  logic [31:0] quot, rem;
  logic        rdy, busy;

  int   testsRun = 0;
  int   failCount = 0;
  exp_t scoreboard[$];

  divider #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .op1_i    (op1),
    .op2_i    (op2),
    .signed_i (sgn),
    .vld_i    (vld),
    .quot_o   (quot),
    .rem_o    (rem),
    .rdy_o    (rdy),
    .busy_o   (busy)
  );

  always #5 clk = ~clk;

  // Reference model straight from the RV32M definition, independent of the algorithm
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    int   sa, sbv;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000;
      e.r = 32'd0;
    end else if (s) begin
      sa  = a;
      sbv = b;
      e.q = 32'(sa / sbv);
      e.r = 32'(sa % sbv);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives a one-cycle start request; returns at the negedge of cycle 1 after fire
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                               input bit pushExp, input string tag);
    @(negedge clk);
    op1 = a;
    op2 = b;
    sgn = s;
    vld = 1'b1;
    if (pushExp) scoreboard.push_back(model(a, b, s));
    @(negedge clk);
    vld = 1'b0;
    op1 = $urandom;
    op2 = $urandom;
    checkOutput({tag, " busy after fire"}, {31'd0, busy}, 32'd1);
  endtask

  // Waits (bounded) for the strobe, checks latency, data and one-cycle width
  task automatic waitResult(input string tag);
    int   cyc = 1;
    bit   found = 0;
    exp_t e;
    while (!found && cyc < 60) begin
      if (rdy) found = 1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    checkOutput({tag, " latency"}, found ? 32'(cyc) : 32'd0, 32'(DIV_LATENCY));
    if (found) begin
      if (scoreboard.size() > 0) begin
        e = scoreboard.pop_front();
        checkOutput({tag, " quot"}, quot, e.q);
        checkOutput({tag, " rem"}, rem, e.r);
      end else begin
        checkOutput({tag, " scoreboard empty"}, 32'd0, 32'd1);
      end
      @(negedge clk);
      checkOutput({tag, " rdy width"}, {31'd0, rdy}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   cyc;
    int   rdyCount;
    int   rdyCycle[2];
    exp_t e;
    logic [31:0] a, b;

    rst = 1'b1;
    vld = 1'b0;
    op1 = '0;
    op2 = '0;
    sgn = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset rdy", {31'd0, rdy}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset quot", quot, 32'd0);
    checkOutput("reset rem", rem, 32'd0);

    // Reset and vld in the same cycle: reset wins
    op1 = 32'd20;
    op2 = 32'd4;
    rst = 1'b1;
    vld = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vld = 1'b0;
    checkOutput("rst+vld busy", {31'd0, busy}, 32'd0);

    applyStimulus(32'd100, 32'd7, 1'b0, 1, "udiv 100/7");
    waitResult("udiv 100/7");

    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 1, "sdiv -7/2");
    checkOutput("quot held at fire", quot, 32'd14);
    waitResult("sdiv -7/2");

    applyStimulus(32'h0000_1234, 32'd0, 1'b1, 1, "sdiv by zero");
    waitResult("sdiv by zero");
    applyStimulus(32'h0000_1234, 32'd0, 1'b0, 1, "udiv by zero");
    waitResult("udiv by zero");

    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1, "sdiv overflow");
    waitResult("sdiv overflow");
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1, "udiv intmin");
    waitResult("udiv intmin");

    applyStimulus(32'hFFFF_FF9C, 32'd7, 1'b1, 1, "sdiv -100/7");
    waitResult("sdiv -100/7");
    applyStimulus(32'd100, 32'hFFFF_FFF9, 1'b1, 1, "sdiv 100/-7");
    waitResult("sdiv 100/-7");
    applyStimulus(32'h8000_0000, 32'd3, 1'b1, 1, "sdiv intmin/3");
    waitResult("sdiv intmin/3");

    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 28);
      applyStimulus(a, b, i[0], 1, "random");
      waitResult("random");
    end

    // vld held high: second fire lands in the first IDLE cycle after DONE
    @(negedge clk);
    op1 = 32'd10;
    op2 = 32'd3;
    sgn = 1'b0;
    vld = 1'b1;
    scoreboard.push_back(model(32'd10, 32'd3, 1'b0));
    cyc = 0;
    rdyCount = 0;
    while (rdyCount < 2 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (cyc == 5) begin
        op1 = 32'd9;
        op2 = 32'd9;
        scoreboard.push_back(model(32'd9, 32'd9, 1'b0));
      end
      if (rdy) begin
        rdyCycle[rdyCount] = cyc;
        rdyCount++;
        if (scoreboard.size() > 0) begin
          e = scoreboard.pop_front();
          checkOutput("held vld quot", quot, e.q);
          checkOutput("held vld rem", rem, e.r);
        end else begin
          checkOutput("held vld scoreboard empty", 32'd0, 32'd1);
        end
      end
    end
    vld = 1'b0;
    checkOutput("held vld strobes", 32'(rdyCount), 32'd2);
    if (rdyCount == 2) begin
      checkOutput("held vld first strobe", 32'(rdyCycle[0]), 32'd34);
      checkOutput("held vld second strobe", 32'(rdyCycle[1]), 32'd69);
    end
    @(negedge clk);
    checkOutput("held vld idle after", {31'd0, busy}, 32'd0);

    // Reset mid-operation aborts with no strobe
    applyStimulus(32'd50, 32'd5, 1'b0, 0, "abort 50/5");
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    checkOutput("abort quot", quot, 32'd0);
    checkOutput("abort rem", rem, 32'd0);
    rdyCount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rdy) rdyCount++;
    end
    checkOutput("abort no strobe", 32'(rdyCount), 32'd0);

    applyStimulus(32'd50, 32'd5, 1'b0, 1, "after abort");
    waitResult("after abort");

    checkOutput("scoreboard drained", 32'(scoreboard.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
